// File: rtl/rcc_pclk_timer_div_mc.sv
// APB/timer kernel clock divider: one prescaled pclk plus NUM_TIM phase-aligned timer clocks.
// Ratio changes are shadowed and applied only on the last cycle of a pclk period.
module rcc_pclk_timer_div_mc #(
  parameter int unsigned       PRE_W        = 3,
  parameter int unsigned       NUM_TIM      = 2,
  parameter logic [PRE_W-1:0]  RST_DIV_SEL  = '0,
  parameter logic [1:0]        RST_TIM_MODE = 2'b00
) (
  input  logic                   i_clk,
  input  logic                   rst_n,
  input  logic [PRE_W-1:0]       div_sel,
  input  logic [2*NUM_TIM-1:0]   tim_mode,
  output logic                   pclk,
  output logic                   pclk_en,
  output logic [NUM_TIM-1:0]     tim_ker_clk,
  output logic [NUM_TIM-1:0]     tim_en,
  output logic                   div_en,
  output logic                   upd_pending
);

  localparam int unsigned CNT_W  = 2 ** (PRE_W - 1);
  localparam int unsigned EXP_W  = $clog2(CNT_W + 1);
  localparam int unsigned MODE_W = 2 * NUM_TIM;

  logic [PRE_W-1:0]  a_sel_q, a_sel_d;
  logic [MODE_W-1:0] a_mode_q, a_mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [EXP_W-1:0]  e_p;
  logic [CNT_W-1:0]  m_p;
  logic [EXP_W-1:0]  e_t [NUM_TIM];
  logic [CNT_W-1:0]  m_t [NUM_TIM];
  logic              period_end;
  logic              boundary;

  logic              pclk_lat;
  logic [NUM_TIM-1:0] tim_lat;

  function automatic logic [CNT_W-1:0] exp_mask(input logic [EXP_W-1:0] e);
    logic [CNT_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(CNT_W); i++) begin
      m[i] = (i < int'(e));
    end
    return m;
  endfunction

  // Exponents and masks from the applied configuration
  always_comb begin
    e_p = '0;
    if (a_sel_q[PRE_W-1]) begin
      e_p = EXP_W'(a_sel_q[PRE_W-2:0]) + EXP_W'(1);
    end
    m_p = exp_mask(e_p);
    for (int i = 0; i < int'(NUM_TIM); i++) begin
      e_t[i] = '0;
      case (a_mode_q[2*i +: 2])
        2'b00:   e_t[i] = (e_p > EXP_W'(0)) ? e_p - EXP_W'(1) : '0;
        2'b01:   e_t[i] = (e_p > EXP_W'(1)) ? e_p - EXP_W'(2) : '0;
        2'b10:   e_t[i] = '0;
        default: e_t[i] = e_p;
      endcase
      m_t[i] = exp_mask(e_t[i]);
    end
  end

  assign upd_pending = ({div_sel, tim_mode} != {a_sel_q, a_mode_q});
  assign period_end  = (cnt_q == m_p);
  assign boundary    = upd_pending && period_end;

  // Next state: shadow load restarts the period, otherwise count and wrap
  always_comb begin
    a_sel_d  = a_sel_q;
    a_mode_d = a_mode_q;
    cnt_d    = cnt_q + CNT_W'(1);
    if (boundary) begin
      a_sel_d  = div_sel;
      a_mode_d = tim_mode;
      cnt_d    = '0;
    end else if (period_end) begin
      cnt_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sel_q  <= RST_DIV_SEL;
      a_mode_q <= {NUM_TIM{RST_TIM_MODE}};
      cnt_q    <= '0;
    end else begin
      a_sel_q  <= a_sel_d;
      a_mode_q <= a_mode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Enables decoded from registered count only
  always_comb begin
    pclk_en = ((cnt_q & m_p) == '0);
    div_en  = (e_p != '0);
    for (int i = 0; i < int'(NUM_TIM); i++) begin
      tim_en[i] = ((cnt_q & m_t[i]) == '0);
    end
  end

  // Clock-gate latches, transparent while i_clk is low
  always_latch begin
    if (!rst_n) begin
      pclk_lat <= 1'b0;
      tim_lat  <= '0;
    end else if (!i_clk) begin
      pclk_lat <= pclk_en;
      tim_lat  <= tim_en;
    end
  end

  assign pclk        = i_clk & pclk_lat;
  assign tim_ker_clk = {NUM_TIM{i_clk}} & tim_lat;

endmodule

// File: tb/tb_rcc_pclk_timer_div_mc.sv
// Bench for rcc_pclk_timer_div_mc: arithmetic period/phase model checked every cycle,
// plus directed scenarios with hand-computed pulse counts.
module tb_rcc_pclk_timer_div_mc;

  localparam int PRE_W   = 3;
  localparam int NUM_TIM = 2;

  logic                 i_clk = 1'b0;
  logic                 rst_n;
  logic [PRE_W-1:0]     div_sel;
  logic [2*NUM_TIM-1:0] tim_mode;
  logic                 pclk, pclk_en, div_en, upd_pending;
  logic [NUM_TIM-1:0]   tim_ker_clk, tim_en;

  int checks   = 0;
  int failures = 0;

  // Model: applied selector, applied packed modes, phase within current pclk period
  int m_sel, m_mode_pk, m_ph;

  rcc_pclk_timer_div_mc #(
    .PRE_W(PRE_W), .NUM_TIM(NUM_TIM), .RST_DIV_SEL(3'b000), .RST_TIM_MODE(2'b00)
  ) dut (
    .i_clk(i_clk), .rst_n(rst_n), .div_sel(div_sel), .tim_mode(tim_mode),
    .pclk(pclk), .pclk_en(pclk_en), .tim_ker_clk(tim_ker_clk), .tim_en(tim_en),
    .div_en(div_en), .upd_pending(upd_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_ep(input int sel);
    if (((sel >> (PRE_W - 1)) & 1) == 0) return 0;
    return (sel & ((1 << (PRE_W - 1)) - 1)) + 1;
  endfunction

  function automatic int f_et(input int mode, input int ep);
    case (mode)
      0:       return (ep > 0) ? ep - 1 : 0;
      1:       return (ep > 1) ? ep - 2 : 0;
      2:       return 0;
      default: return ep;
    endcase
  endfunction

  function automatic int mdl_pen();
    return ((m_ph % (1 << f_ep(m_sel))) == 0) ? 1 : 0;
  endfunction

  function automatic int mdl_ten();
    int r;
    r = 0;
    for (int i = 0; i < NUM_TIM; i++) begin
      if ((m_ph % (1 << f_et((m_mode_pk >> (2*i)) & 3, f_ep(m_sel)))) == 0) r |= (1 << i);
    end
    return r;
  endfunction

  function automatic int mdl_pend();
    return ((int'(div_sel) != m_sel) || (int'(tim_mode) != m_mode_pk)) ? 1 : 0;
  endfunction

  task automatic mdl_reset();
    m_sel = 0; m_mode_pk = 0; m_ph = 0;
  endtask

  // Compare process: model steps on each rising edge, outputs checked in both phases
  initial begin
    int prev_pen, prev_ten, per;
    mdl_reset();
    forever begin
      @(posedge i_clk);
      prev_pen = mdl_pen();
      prev_ten = mdl_ten();
      if (!rst_n) begin
        mdl_reset();
      end else begin
        per = 1 << f_ep(m_sel);
        if (mdl_pend() == 1 && m_ph == per - 1) begin
          m_sel = int'(div_sel); m_mode_pk = int'(tim_mode); m_ph = 0;
        end else begin
          m_ph = (m_ph + 1) % per;
        end
      end
      #1;
      chk("pclk_high", int'(pclk), rst_n ? prev_pen : 0);
      chk("tim_clk_high", int'(tim_ker_clk), rst_n ? prev_ten : 0);
      @(negedge i_clk);
      #1;
      if (!rst_n) mdl_reset();
      chk("pclk_en", int'(pclk_en), mdl_pen());
      chk("tim_en", int'(tim_en), mdl_ten());
      chk("div_en", int'(div_en), (f_ep(m_sel) != 0) ? 1 : 0);
      chk("upd_pending", int'(upd_pending), mdl_pend());
      chk("pclk_low", int'(pclk), 0);
      chk("tim_clk_low", int'(tim_ker_clk), 0);
    end
  end

  // Counts over n cycles; starts from a point after negedge (before next posedge)
  task automatic run_count(input int n, output int c_pen, output int c_t0, output int c_t1,
                           output int c_pend, output int c_pclk, output int c_bad);
    c_pen = 0; c_t0 = 0; c_t1 = 0; c_pend = 0; c_pclk = 0; c_bad = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      c_pclk += int'(pclk);
      @(negedge i_clk); #1;
      c_pen  += int'(pclk_en);
      c_t0   += int'(tim_en[0]);
      c_t1   += int'(tim_en[1]);
      c_pend += int'(upd_pending);
      if (pclk_en && tim_en != 2'b11) c_bad++;
    end
  endtask

  // Returns at negedge+1 of the cycle where the model reaches the given state
  task automatic wait_state(input string name, input int sel, input int mode, input int ph);
    int ok;
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk); #1;
      if (m_sel == sel && m_mode_pk == mode && m_ph == ph && rst_n) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int pen, t0, t1, pend, pc, bad, hold;
    rst_n = 1'b0; div_sel = '0; tim_mode = '0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_pclk", int'(pclk), 0);
    chk("rst_pclk_en", int'(pclk_en), 1);
    chk("rst_tim_en", int'(tim_en), 3);
    #1 rst_n = 1'b1;

    // /1, modes 00: everything every cycle
    run_count(8, pen, t0, t1, pend, pc, bad);
    chk("div1_pen", pen, 8);
    chk("div1_t0", t0, 8);
    chk("div1_pclk_pulses", pc, 8);
    chk("div1_div_en", int'(div_en), 0);

    // /4, ch0=00 (/2), ch1=01 (/1)
    #1 div_sel = 3'b101; tim_mode = 4'b0100;
    run_count(16, pen, t0, t1, pend, pc, bad);
    chk("div4_pen", pen, 4);
    chk("div4_t0", t0, 8);
    chk("div4_t1", t1, 16);
    chk("div4_coincide", bad, 0);
    chk("div4_div_en", int'(div_en), 1);

    // /16, ch0=10 (i_clk), ch1=11 (= pclk)
    #1 div_sel = 3'b111; tim_mode = 4'b1110;
    wait_state("wait_div16", 7, 14, 0);
    run_count(32, pen, t0, t1, pend, pc, bad);
    chk("div16_pen", pen, 2);
    chk("div16_t0", t0, 32);
    chk("div16_t1", t1, 2);
    chk("div16_pclk_pulses", pc, 2);

    // Request /2 mid-period at phase 5: pending for the rest of the period
    wait_state("wait_ph5", 7, 14, 5);
    #1 div_sel = 3'b100;
    run_count(12, pen, t0, t1, pend, pc, bad);
    chk("upd_pend_cycles", pend, 10);
    chk("upd_new_pen", pen, 1);
    run_count(8, pen, t0, t1, pend, pc, bad);
    chk("div2_pen", pen, 4);

    // Mode change landing exactly in the boundary cycle
    #1 div_sel = 3'b111;
    wait_state("wait_ph15", 7, 14, 15);
    #1 tim_mode = 4'b0010;
    #1 chk("bnd_pend_now", int'(upd_pending), 1);
    @(negedge i_clk); #1;
    chk("bnd_pend_next", int'(upd_pending), 0);
    chk("bnd_pen_next", int'(pclk_en), 1);

    // Asynchronous reset mid-period at phase 7 while tim clock ch0 runs every cycle
    wait_state("wait_ph7", 7, 2, 7);
    @(posedge i_clk); #3;
    chk("pre_rst_tim0_high", int'(tim_ker_clk[0]), 1);
    rst_n = 1'b0; div_sel = '0; tim_mode = '0;
    #1;
    chk("rst_pclk_drop", int'(pclk), 0);
    chk("rst_tim_drop", int'(tim_ker_clk), 0);
    @(negedge i_clk); #1;
    chk("rst_div_en", int'(div_en), 0);
    #1 rst_n = 1'b1;
    run_count(4, pen, t0, t1, pend, pc, bad);
    chk("post_rst_pen", pen, 4);
    chk("post_rst_pclk_pulses", pc, 4);

    // Randomized configuration changes and occasional resets
    for (int it = 0; it < 40; it++) begin
      #1;
      div_sel  = PRE_W'($urandom_range(0, 7));
      tim_mode = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 40);
      repeat (hold) @(negedge i_clk);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge i_clk); #3 rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge i_clk);
        #2 rst_n = 1'b1;
        @(negedge i_clk);
      end
    end

    repeat (3) @(negedge i_clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/rcc_pclk_timer_div_mc.md
Name: rcc_pclk_timer_div_mc

Overview:
- Parametrised successor to the single-timer APB/timer clock divider.
- Generates one APB bus clock and NUM_TIM independently configured timer kernel clocks from one source clock.
- Timer clocks are always phase-aligned to pclk.
- Ratio changes are glitch-free: they take effect only at a pclk period boundary, and a pending-update flag is reported.
- Sits in the RCC between the AHB/system clock and each APB domain.

Parameters:
- PRE_W, 3, width of div_sel. MSB=0 gives /1. MSB=1 gives /2^(low bits + 1), so PRE_W=3 covers /2../16.
- NUM_TIM, 2, number of timer kernel clock channels.
- RST_DIV_SEL, 0, div_sel value applied at reset.
- RST_TIM_MODE, 0, mode applied to every timer channel at reset.

Ports:
- i_clk  input  1  source clock
- rst_n  input  1  asynchronous active-low reset
- div_sel  input  PRE_W  APB prescaler select, quasi-static
- tim_mode  input  2*NUM_TIM  per-channel timer mode, 2 bits per channel (channel i = bits [2i+1:2i])
- pclk  output  1  gated APB clock
- pclk_en  output  1  APB clock-enable, one i_clk cycle wide
- tim_ker_clk  output  NUM_TIM  gated timer kernel clocks
- tim_en  output  NUM_TIM  timer clock-enables
- div_en  output  1  high when applied APB ratio > 1
- upd_pending  output  1  requested config differs from applied config

Behaviour:
- Prescaler exponent from applied div_sel (a_sel):
  - e_p = 0 if a_sel[MSB]=0.
  - Otherwise e_p = a_sel[PRE_W-2:0] + 1.
  - Counter width CNT_W = 2^(PRE_W-1). Mask m_p = 2^e_p - 1.
- Timer exponent per channel from applied mode:
  - 00: e_t = max(0, e_p-1) (x2 multiplier)
  - 01: e_t = max(0, e_p-2) (x4 multiplier)
  - 10: e_t = 0 (always i_clk)
  - 11: e_t = e_p (equal to pclk)
  - Mask m_t = 2^e_t - 1.
- Counter cnt (CNT_W bits):
  - Increments every i_clk.
  - Wraps to 0 when cnt == m_p.
  - Held at 0 when e_p = 0.
- pclk_en = ((cnt & m_p) == 0). tim_en[i] = ((cnt & m_t[i]) == 0).
  - Both are decoded only from registered state.
  - Because m_t is a subset of m_p, every pclk_en pulse coincides with a tim_en pulse on every channel.
- Gated clocks:
  - Each output clock = i_clk AND L(en), where L is a latch transparent while i_clk is low.
  - Each clock therefore has one i_clk high phase per period.
  - Each latch is asynchronously cleared by reset.
- div_en = (e_p != 0).
- Shadow update:
  - upd_pending = ({div_sel, tim_mode} != {a_sel, a_mode}), combinational.
  - Boundary condition: on the edge where upd_pending=1 and cnt == m_p (the last cycle of the current pclk period; every cycle when e_p = 0), load a_sel <= div_sel and a_mode <= tim_mode, and set cnt <= 0.
  - The next cycle is therefore the first cycle of the new period, with pclk_en=1.
  - Inputs are sampled only on that edge; intermediate input changes are ignored.
  - Never truncate a period and never emit a runt pulse.
- Simultaneous events: a change arriving in the boundary cycle itself is applied on that edge.
- Reset (asynchronous, any time including mid-period or mid-update):
  - cnt=0, a_sel=RST_DIV_SEL, a_mode=RST_TIM_MODE.
  - Latches cleared, so pclk=0 and tim_ker_clk=0.
  - pclk_en=1, tim_en=all 1.
  - div_en per RST_DIV_SEL.
- After reset release:
  - First i_clk edge advances cnt.
  - First gated high phase occurs in the first i_clk high after release.
- Latency: the applied ratio changes at most 2^e_p cycles after a config change (the current period completes first).
- Out-of-range values do not exist: every encoding is legal.

Test Plan:
- Reset with RST_DIV_SEL=0, all modes 00 -> pclk_en and tim_en constantly 1; pclk mirrors i_clk high phases; div_en=0.
- div_sel=3'b101 (/4), modes ch0=00, ch1=01 -> pclk_en every 4th cycle; tim_en[0] every 2nd cycle; tim_en[1] every cycle; div_en=1; every pclk_en cycle also has both tim_en=1.
- div_sel=3'b111 (/16), modes ch0=10, ch1=11 -> tim_en[0] every cycle; tim_en[1] identical to pclk_en (period 16); 1 gated high pulse per 16 i_clk.
- While /16 is active with cnt=5, write div_sel=3'b100 -> upd_pending=1 for 10 cycles; new /2 starts exactly at the cycle after cnt=15; no pulse interval differs from 16 or 2.
- At the cnt=15 boundary cycle, change tim_mode ch1 11->00 simultaneously -> applied on that edge; upd_pending low next cycle.
- Assert rst_n low at cnt=7 of /16 -> pclk/tim_ker_clk drop to 0 immediately; on release the counter restarts from 0 with reset ratios.
